// File: rtl/gol_video_pkg.sv
// rtl/gol_video_pkg.sv - shared timing constants, colour type and cell indexing for the grid renderer
package gol_video_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // Counter width sized for the default 800x525 raster; smaller rasters fit too.
  localparam int CNT_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

  localparam int GRID_N = 8;

  typedef logic [23:0] rgb_t;

  function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running h/v raster counters with sync windows and active flag
module vga_timing_gen
  import gol_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_win,
  output logic             vsync_win,
  output logic             line_last,
  output logic             frame_last
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_0   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_1   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_0   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_1   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign line_last  = (h_cnt == H_LAST);
  assign frame_last = line_last && (v_cnt == V_LAST);
  assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_win  = (h_cnt >= HS_0) && (h_cnt < HS_1);
  assign vsync_win  = (v_cnt >= VS_0) && (v_cnt < VS_1);

endmodule

// File: rtl/grid_video_renderer.sv
// rtl/grid_video_renderer.sv - renders the 8x8 life grid as a centred board of square cells
module grid_video_renderer
  import gol_video_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter int   CELL_PX    = 60,
  parameter int   X_OFFSET   = 80,
  parameter int   SHOW_LINES = 1,
  parameter rgb_t ALIVE_RGB  = 24'hFFFFFF,
  parameter rgb_t DEAD_RGB   = 24'h000000,
  parameter rgb_t LINE_RGB   = 24'h404040,
  parameter rgb_t BG_RGB     = 24'h000040
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic        frame_start,
  output logic        grid_taken,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output rgb_t        rgb
);

  localparam int BOARD = GRID_N * CELL_PX;
  localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
  localparam logic [CNT_W-1:0] BX_0     = CNT_W'(X_OFFSET);
  localparam logic [CNT_W-1:0] BX_1     = CNT_W'(X_OFFSET + BOARD);
  localparam logic [CNT_W-1:0] BX_LAST  = CNT_W'(X_OFFSET + BOARD - 1);
  localparam logic [CNT_W-1:0] BY_1     = CNT_W'(BOARD);
  localparam logic [CNT_W-1:0] BY_LAST  = CNT_W'(BOARD - 1);

  if (X_OFFSET + BOARD > H_ACTIVE || BOARD > V_ACTIVE) begin : g_param_check
    $error("grid_video_renderer: board does not fit inside the active area");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active, hsync_win, vsync_win, line_last, frame_last;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hsync_win  (hsync_win),
    .vsync_win  (vsync_win),
    .line_last  (line_last),
    .frame_last (frame_last)
  );

  logic [SUB_W-1:0] x_sub, y_sub;
  logic [2:0]       col, row;
  logic [63:0]      shadow;
  logic             in_board;
  rgb_t             pixel;

  // Cell counters always describe the current h_cnt/v_cnt, so they are
  // cleared one step before the board edge and stepped while inside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_sub <= '0;
      col   <= '0;
      y_sub <= '0;
      row   <= '0;
    end else begin
      if (h_cnt >= BX_0 && h_cnt < BX_LAST) begin
        if (x_sub == SUB_LAST) begin
          x_sub <= '0;
          col   <= col + 3'd1;
        end else begin
          x_sub <= x_sub + 1'b1;
        end
      end else begin
        x_sub <= '0;
        col   <= '0;
      end
      if (line_last) begin
        if (v_cnt < BY_LAST) begin
          if (y_sub == SUB_LAST) begin
            y_sub <= '0;
            row   <= row + 3'd1;
          end else begin
            y_sub <= y_sub + 1'b1;
          end
        end else begin
          y_sub <= '0;
          row   <= '0;
        end
      end
    end
  end

  assign in_board = (h_cnt >= BX_0) && (h_cnt < BX_1) && (v_cnt < BY_1);

  always_comb begin
    pixel = BG_RGB;
    if (in_board) begin
      if (SHOW_LINES != 0 && (x_sub == '0 || y_sub == '0)) pixel = LINE_RGB;
      else if (shadow[cell_idx(row, col)])                pixel = ALIVE_RGB;
      else                                                 pixel = DEAD_RGB;
    end
  end

  // Shadow only moves on the last pixel of the frame so an image never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= '0;
      grid_taken  <= 1'b0;
      frame_start <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      rgb         <= '0;
    end else begin
      if (frame_last && grid_valid) shadow <= grid;
      grid_taken  <= frame_last && grid_valid;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hsync_n     <= ~hsync_win;
      vsync_n     <= ~vsync_win;
      de          <= active;
      rgb         <= active ? pixel : '0;
    end
  end

endmodule
